// File: rtl/dispatch_pkg.sv
// Shared constants for the dispatch stage: major opcodes, station indices and field widths.
package dispatch_pkg;

   localparam int MAJOR_W    = 4;
   localparam int SRC_W      = 5;
   localparam int OFFSCALE_W = 2;
   localparam int DEST_W     = 5;
   localparam int MINOR_W    = 4;
   localparam int ADDR_W     = 48;
   localparam int NUM_ST     = 4;

   localparam logic [MAJOR_W-1:0] OP_NOP    = 4'd0;
   localparam logic [MAJOR_W-1:0] OP_INT    = 4'd1;
   localparam logic [MAJOR_W-1:0] OP_FPADD  = 4'd2;
   localparam logic [MAJOR_W-1:0] OP_FPMUL  = 4'd3;
   localparam logic [MAJOR_W-1:0] OP_LOAD   = 4'd4;
   localparam logic [MAJOR_W-1:0] OP_STORE  = 4'd5;
   localparam logic [MAJOR_W-1:0] OP_BRANCH = 4'd6;

   localparam int ST_INT   = 0;
   localparam int ST_FPADD = 1;
   localparam int ST_FPMUL = 2;
   localparam int ST_LSB   = 3;

endpackage

// File: rtl/rob_tag_alloc.sv
// Reorder-buffer tag pointer and occupancy tracking; full is judged on the pre-edge count.
module rob_tag_alloc #(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 issue,
   input  logic                 retire,
   input  logic                 flush,
   output logic [ROB_TAG_W-1:0] tag,
   output logic                 full
);

   localparam logic [ROB_TAG_W:0] DEPTH_CNT = ROB_DEPTH[ROB_TAG_W:0];

   logic [ROB_TAG_W:0] count;
   logic               dec;

   // A retire against an empty ROB carries no information and is dropped.
   assign dec  = retire && (count != '0);
   assign full = (count >= DEPTH_CNT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag   <= '0;
         count <= '0;
      end else if (flush) begin
         tag   <= '0;
         count <= '0;
      end else begin
         if (issue) tag <= tag + 1'b1;
         case ({issue, dec})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dispatch_unit.sv
// In-order dispatch: one-entry hold register, major-opcode decode to a station, ROB tag allocation.
module dispatch_unit
   import dispatch_pkg::*;
#(
   parameter int ROB_DEPTH = 16,
   parameter int ROB_TAG_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  instr_valid_in,
   input  logic [MAJOR_W-1:0]    MajorOpcode_in,
   input  logic [SRC_W-1:0]      Source1_in,
   input  logic [SRC_W-1:0]      Source2_in,
   input  logic [OFFSCALE_W-1:0] OffsetScale_in,
   input  logic [DEST_W-1:0]     Destination_in,
   input  logic [MINOR_W-1:0]    MinorOpcode_in,
   input  logic                  HasAddress_in,
   input  logic [ADDR_W-1:0]     Address_in,
   input  logic                  OffsetSub_in,
   output logic                  instr_pop_out,
   input  logic                  int_rs_ready_in,
   input  logic                  fpadd_rs_ready_in,
   input  logic                  fpmul_rs_ready_in,
   input  logic                  lsb_ready_in,
   input  logic                  rob_retire_in,
   input  logic                  flush_in,
   output logic [NUM_ST-1:0]     issue_valid_out,
   output logic [MAJOR_W-1:0]    MajorOpcode_out,
   output logic [SRC_W-1:0]      Source1_out,
   output logic [SRC_W-1:0]      Source2_out,
   output logic [OFFSCALE_W-1:0] OffsetScale_out,
   output logic [DEST_W-1:0]     Destination_out,
   output logic [MINOR_W-1:0]    MinorOpcode_out,
   output logic                  HasAddress_out,
   output logic [ADDR_W-1:0]     Address_out,
   output logic                  OffsetSub_out,
   output logic [ROB_TAG_W-1:0]  rob_tag_out,
   output logic                  stall_out,
   output logic                  illegal_op_out,
   output logic [31:0]           issue_count_out
);

   logic              hold_valid;
   logic [NUM_ST-1:0] target;
   logic [NUM_ST-1:0] station_ready;
   logic              decodable;
   logic              is_illegal;
   logic              rob_full;
   logic              can_issue;
   logic              leaving;

   always_comb begin
      target    = '0;
      decodable = 1'b1;
      case (MajorOpcode_out)
         OP_INT, OP_BRANCH:  target[ST_INT]   = 1'b1;
         OP_FPADD:           target[ST_FPADD] = 1'b1;
         OP_FPMUL:           target[ST_FPMUL] = 1'b1;
         OP_LOAD, OP_STORE:  target[ST_LSB]   = 1'b1;
         default:            decodable        = 1'b0;
      endcase
   end

   assign is_illegal    = hold_valid && (MajorOpcode_out > OP_BRANCH);
   assign station_ready = {lsb_ready_in, fpmul_rs_ready_in, fpadd_rs_ready_in, int_rs_ready_in};

   // NOP and illegal entries have an all-zero target, so they can never issue.
   assign can_issue = hold_valid && |(target & station_ready) && !rob_full && !flush_in;
   assign leaving   = hold_valid && !flush_in && (can_issue || !decodable);

   assign issue_valid_out = can_issue ? target : '0;
   assign stall_out       = hold_valid && decodable && !can_issue;
   assign instr_pop_out   = !rst && instr_valid_in && !flush_in && (!hold_valid || leaving);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_valid      <= 1'b0;
         MajorOpcode_out <= '0;
         Source1_out     <= '0;
         Source2_out     <= '0;
         OffsetScale_out <= '0;
         Destination_out <= '0;
         MinorOpcode_out <= '0;
         HasAddress_out  <= 1'b0;
         Address_out     <= '0;
         OffsetSub_out   <= 1'b0;
      end else if (flush_in) begin
         hold_valid <= 1'b0;
      end else if (instr_pop_out) begin
         hold_valid      <= 1'b1;
         MajorOpcode_out <= MajorOpcode_in;
         Source1_out     <= Source1_in;
         Source2_out     <= Source2_in;
         OffsetScale_out <= OffsetScale_in;
         Destination_out <= Destination_in;
         MinorOpcode_out <= MinorOpcode_in;
         HasAddress_out  <= HasAddress_in;
         Address_out     <= Address_in;
         OffsetSub_out   <= OffsetSub_in;
      end else if (leaving) begin
         // Fields stay put after the entry leaves so waveforms show the last instruction.
         hold_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_op_out <= 1'b0;
      end else if (is_illegal) begin
         illegal_op_out <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_count_out <= '0;
      end else if (flush_in) begin
         issue_count_out <= '0;
      end else if (can_issue && (issue_count_out != '1)) begin
         issue_count_out <= issue_count_out + 32'd1;
      end
   end

   rob_tag_alloc #(
      .ROB_DEPTH (ROB_DEPTH),
      .ROB_TAG_W (ROB_TAG_W)
   ) u_rob_tag_alloc (
      .clk    (clk),
      .rst    (rst),
      .issue  (can_issue),
      .retire (rob_retire_in),
      .flush  (flush_in),
      .tag    (rob_tag_out),
      .full   (rob_full)
   );

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: an instruction-queue driver plus a per-cycle reference model.
module tb_dispatch_unit;
   import dispatch_pkg::*;

   localparam int DEPTH = 16;

   typedef logic [74:0]  instr_t;
   typedef logic [117:0] vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid_in;
   logic [3:0]  MajorOpcode_in;
   logic [4:0]  Source1_in, Source2_in, Destination_in;
   logic [1:0]  OffsetScale_in;
   logic [3:0]  MinorOpcode_in;
   logic        HasAddress_in, OffsetSub_in;
   logic [47:0] Address_in;
   logic        instr_pop_out;
   logic        int_rs_ready_in, fpadd_rs_ready_in, fpmul_rs_ready_in, lsb_ready_in;
   logic        rob_retire_in, flush_in;
   logic [3:0]  issue_valid_out;
   logic [3:0]  MajorOpcode_out;
   logic [4:0]  Source1_out, Source2_out, Destination_out;
   logic [1:0]  OffsetScale_out;
   logic [3:0]  MinorOpcode_out;
   logic        HasAddress_out, OffsetSub_out;
   logic [47:0] Address_out;
   logic [3:0]  rob_tag_out;
   logic        stall_out, illegal_op_out;
   logic [31:0] issue_count_out;

   always #5 clk = ~clk;

   dispatch_unit #(.ROB_DEPTH(16), .ROB_TAG_W(4)) dut (
      .clk(clk), .rst(rst), .instr_valid_in(instr_valid_in),
      .MajorOpcode_in(MajorOpcode_in), .Source1_in(Source1_in), .Source2_in(Source2_in),
      .OffsetScale_in(OffsetScale_in), .Destination_in(Destination_in),
      .MinorOpcode_in(MinorOpcode_in), .HasAddress_in(HasAddress_in),
      .Address_in(Address_in), .OffsetSub_in(OffsetSub_in),
      .instr_pop_out(instr_pop_out),
      .int_rs_ready_in(int_rs_ready_in), .fpadd_rs_ready_in(fpadd_rs_ready_in),
      .fpmul_rs_ready_in(fpmul_rs_ready_in), .lsb_ready_in(lsb_ready_in),
      .rob_retire_in(rob_retire_in), .flush_in(flush_in),
      .issue_valid_out(issue_valid_out),
      .MajorOpcode_out(MajorOpcode_out), .Source1_out(Source1_out), .Source2_out(Source2_out),
      .OffsetScale_out(OffsetScale_out), .Destination_out(Destination_out),
      .MinorOpcode_out(MinorOpcode_out), .HasAddress_out(HasAddress_out),
      .Address_out(Address_out), .OffsetSub_out(OffsetSub_out),
      .rob_tag_out(rob_tag_out), .stall_out(stall_out),
      .illegal_op_out(illegal_op_out), .issue_count_out(issue_count_out)
   );

   int nvec = 0;
   int nfail = 0;

   instr_t iq[$];

   // Reference model: what the dispatch stage holds and has done, in plain terms.
   bit     m_hv;
   instr_t m_hold;
   int     m_rob, m_tag;
   longint m_cnt;
   bit     m_ill;
   bit     cur_fl, cur_ret;
   logic [3:0] e_issue;
   bit     e_can, e_leave, e_pop, e_stall;
   vec_t   exp_v;

   function automatic int station(input logic [3:0] op);
      case (op)
         4'd1, 4'd6: return 0;
         4'd2:       return 1;
         4'd3:       return 2;
         4'd4, 4'd5: return 3;
         default:    return -1;
      endcase
   endfunction

   function automatic instr_t mk(input logic [3:0] op);
      logic [63:0] a;
      a = {$urandom, $urandom};
      return {op, 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 4'($urandom),
              1'($urandom), a[47:0], 1'($urandom)};
   endfunction

   function automatic vec_t obs();
      return {issue_valid_out, instr_pop_out, stall_out, rob_tag_out, illegal_op_out,
              MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out, Destination_out,
              MinorOpcode_out, HasAddress_out, Address_out, OffsetSub_out, issue_count_out};
   endfunction

   task automatic model_reset();
      m_hv = 0; m_hold = '0; m_rob = 0; m_tag = 0; m_cnt = 0; m_ill = 0;
   endtask

   task automatic apply(input logic [3:0] r, input bit ret, input bit fl);
      int st;
      bit sr;
      instr_valid_in = (iq.size() > 0);
      {MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in, Destination_in, MinorOpcode_in,
       HasAddress_in, Address_in, OffsetSub_in} = instr_valid_in ? iq[0] : '0;
      {lsb_ready_in, fpmul_rs_ready_in, fpadd_rs_ready_in, int_rs_ready_in} = r;
      rob_retire_in = ret;
      flush_in      = fl;
      cur_fl = fl; cur_ret = ret;
      #2;
      st      = station(m_hold[74:71]);
      sr      = (st >= 0) ? r[st] : 1'b0;
      e_can   = m_hv && sr && (m_rob < DEPTH) && !fl;
      e_issue = e_can ? 4'(1 << st) : 4'b0;
      e_leave = m_hv && !fl && (e_can || st < 0);
      e_pop   = instr_valid_in && !fl && (!m_hv || e_leave);
      e_stall = m_hv && (st >= 0) && !e_can;
      exp_v   = {e_issue, e_pop, e_stall, 4'(m_tag), m_ill, m_hold, 32'(m_cnt)};
   endtask

   task automatic advance();
      @(posedge clk);
      if (m_hv && m_hold[74:71] > 4'd6) m_ill = 1;
      if (cur_fl) begin
         m_hv = 0; m_rob = 0; m_tag = 0; m_cnt = 0;
      end else begin
         if (e_can) begin
            m_tag = (m_tag + 1) % DEPTH;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
         end
         m_rob = m_rob + (e_can ? 1 : 0) - ((cur_ret && m_rob > 0) ? 1 : 0);
         if (e_pop) begin
            m_hold = iq[0];
            m_hv   = 1;
         end else if (e_leave) begin
            m_hv = 0;
         end
      end
      if (e_pop) void'(iq.pop_front());
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      iq.delete();
      apply(4'hF, 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      iq.delete();
      iq.push_back(mk(4'd1));
      apply(4'hF, 1, 0);
      nvec++;
      if (obs() !== '0) begin
         nfail++;
         $display("FAIL reset_outputs: got %h want 0", obs());
      end
      @(posedge clk);
      #1;
      nvec++;
      if (obs() !== '0) begin
         nfail++;
         $display("FAIL reset_after_edge: got %h want 0", obs());
      end
      rst = 1'b0;
      iq.delete();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 4; i++) iq.push_back(mk(4'd1));
      for (int i = 0; i < 6; i++) begin
         apply(4'hF, 0, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL back_to_back cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
      nvec++;
      if (issue_count_out !== 32'd4) begin
         nfail++;
         $display("FAIL back_to_back_count: got %0d want 4", issue_count_out);
      end
   endtask

   task automatic test_stall_in_order();
      do_reset();
      iq.push_back(mk(4'd3));
      iq.push_back(mk(4'd1));
      for (int i = 0; i < 7; i++) begin
         apply((i >= 1 && i <= 3) ? 4'b1011 : 4'hF, 0, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL stall_in_order cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
   endtask

   task automatic test_rob_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) iq.push_back(mk(4'd1));
      for (int i = 0; i < 22; i++) begin
         apply(4'hF, i == 18, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL rob_wrap cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
      nvec++;
      if (issue_count_out !== 32'd17) begin
         nfail++;
         $display("FAIL rob_wrap_count: got %0d want 17", issue_count_out);
      end
   endtask

   task automatic test_issue_retire_full();
      do_reset();
      for (int i = 0; i < 16; i++) iq.push_back(mk(4'd4));
      for (int i = 0; i < 17; i++) begin
         if (i == 16) begin
            iq.push_back(mk(4'd5));
            iq.push_back(mk(4'd1));
         end
         apply(4'hF, i == 16, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL issue_retire_15 cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
      for (int i = 0; i < 3; i++) begin
         apply(4'hF, 0, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL issue_retire_after cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
      nvec++;
      if (stall_out !== 1'b1) begin
         nfail++;
         $display("FAIL issue_retire_full_stall: got %b want 1", stall_out);
      end
   endtask

   task automatic test_nop_illegal();
      do_reset();
      iq.push_back(mk(4'd1));
      iq.push_back(mk(4'd0));
      iq.push_back(mk(4'd9));
      iq.push_back(mk(4'd2));
      for (int i = 0; i < 7; i++) begin
         apply(4'hF, 0, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL nop_illegal cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
      nvec++;
      if (illegal_op_out !== 1'b1 || rob_tag_out !== 4'd2) begin
         nfail++;
         $display("FAIL nop_illegal_final: got ill=%b tag=%0d want ill=1 tag=2",
                  illegal_op_out, rob_tag_out);
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) iq.push_back(mk(4'd6));
      iq.push_back(mk(4'd3));
      iq.push_back(mk(4'd1));
      for (int i = 0; i < 12; i++) begin
         apply(4'b1011, 0, i == 8);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL flush cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
         if (i == 8) begin
            nvec++;
            if (rob_tag_out !== 4'd0 || issue_count_out !== 32'd0 || stall_out !== 1'b0) begin
               nfail++;
               $display("FAIL flush_clear: got tag=%0d cnt=%0d stall=%b want 0 0 0",
                        rob_tag_out, issue_count_out, stall_out);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] op;
      logic [3:0] r;
      int k;
      do_reset();
      for (int i = 0; i < 500; i++) begin
         if (iq.size() < 3) begin
            k = $urandom_range(0, 19);
            if (k == 0)      op = 4'd0;
            else if (k == 1) op = 4'($urandom_range(7, 15));
            else             op = 4'($urandom_range(1, 6));
            iq.push_back(mk(op));
         end
         r = 4'($urandom) | 4'($urandom);
         apply(r, ($urandom % 3) == 0, ($urandom % 50) == 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL random cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         advance();
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) iq.push_back(mk(4'd2));
      for (int i = 0; i < 3; i++) begin
         apply(4'hF, 0, 0);
         nvec++;
         if (obs() !== exp_v) begin
            nfail++;
            $display("FAIL async_pre cyc %0d: got %h want %h", i, obs(), exp_v);
         end
         if (i < 2) advance();
      end
      rst = 1'b1;
      #1;
      nvec++;
      if (obs() !== '0) begin
         nfail++;
         $display("FAIL async_reset: got %h want 0", obs());
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      iq.delete();
   endtask

   initial begin
      rst = 1'b1;
      instr_valid_in = 0;
      {MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in, Destination_in, MinorOpcode_in,
       HasAddress_in, Address_in, OffsetSub_in} = '0;
      {lsb_ready_in, fpmul_rs_ready_in, fpadd_rs_ready_in, int_rs_ready_in} = '0;
      rob_retire_in = 0;
      flush_in = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_back_to_back();
      test_stall_in_order();
      test_rob_wrap();
      test_issue_retire_full();
      test_nop_illegal();
      test_flush();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Sits directly downstream of the instruction queue.
- Each cycle it takes the head instruction from the queue into a one-entry hold register, decodes MajorOpcode to select a target reservation station (integer, FP add, FP mul, load/store buffer), allocates a reorder-buffer tag, and issues the instruction.
- Dispatch is strictly in order: a blocked head instruction stalls everything behind it, even when a later instruction's station is free.

Parameters:
- ROB_DEPTH, 16, number of reorder-buffer entries; power of two, at least 2.
- ROB_TAG_W, 4, equal to log2(ROB_DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- instr_valid_in  in  1  queue head holds a valid instruction
- MajorOpcode_in, Source1_in, Source2_in, OffsetScale_in, Destination_in, MinorOpcode_in, HasAddress_in, Address_in, OffsetSub_in  in  4,5,5,2,5,4,1,48,1  head instruction fields
- instr_pop_out  out  1  queue pops its head at this edge
- int_rs_ready_in, fpadd_rs_ready_in, fpmul_rs_ready_in, lsb_ready_in  in  1 each  station can accept this cycle
- rob_retire_in  in  1  one ROB entry retires this cycle
- flush_in  in  1  synchronous pipeline flush
- issue_valid_out  out  4  one-hot target: bit0 INT, bit1 FPADD, bit2 FPMUL, bit3 LSB
- payload outputs (same nine fields, suffix _out)  out  75 total  hold-register contents
- rob_tag_out  out  ROB_TAG_W  tag allocated to the issued instruction
- stall_out  out  1  hold register valid but blocked
- illegal_op_out  out  1  sticky flag: an illegal opcode was seen
- issue_count_out  out  32  instructions issued since reset or flush

Behaviour:
- Reset: all outputs 0; hold register invalid; tag pointer 0; ROB count 0; illegal flag 0.
- Decode of MajorOpcode (constants in the package):
  - 0 NOP: drop, no issue, no tag.
  - 1 INT and 6 BRANCH: INT station.
  - 2: FPADD station.
  - 3: FPMUL station.
  - 4 LOAD and 5 STORE: LSB station.
  - 7-15: illegal. Set illegal_op_out, drop the instruction, no issue.
- can_issue = hold_valid AND target station ready AND rob_count < ROB_DEPTH. NOP and illegal entries always leave the hold register in one cycle.
- Issue outputs are combinational from the hold register. issue_valid_out is nonzero only when can_issue is true; the station captures on that same edge.
- instr_pop_out = instr_valid_in AND NOT flush_in AND (hold empty OR hold leaving this cycle). This gives one instruction per cycle sustained throughput.
- Latency: an instruction popped at edge N is issued no earlier than the cycle between edges N and N+1. The earliest station capture is edge N+1.
- stall_out = hold_valid AND NOT can_issue, for a decodable opcode.
- ROB tag and count:
  - rob_tag_out is the current tag pointer; it increments mod ROB_DEPTH on each issue and wraps 15 to 0 at the default depth.
  - rob_count increments on issue and decrements on rob_retire_in. Issue and retire in the same cycle leave it unchanged.
  - Retire with count 0 is ignored.
  - An issue is allowed at count ROB_DEPTH-1 when a retire happens in the same cycle. Full is evaluated on the pre-edge count, so the block stays blocked in the cycle that count reaches ROB_DEPTH.
- issue_count_out increments on each issue, saturates at all-ones, and clears on flush.
- Flush (highest priority):
  - In the flush cycle: no issue, no pop.
  - At the next edge: hold register invalidated, tag pointer, rob_count and issue_count cleared. illegal_op_out is retained; only rst clears it.
- Reset asserted mid-issue: outputs go to 0 immediately (asynchronous). The partly issued instruction is lost; upstream and downstream reset together.
- Payload outputs are don't-care when issue_valid_out is 0, but must hold the hold-register value for waveform debug.

Decomposition:
- Package dispatch_pkg:
  - major-opcode localparams (NOP, INT, FPADD, FPMUL, LOAD, STORE, BRANCH)
  - station index constants (INT=0, FPADD=1, FPMUL=2, LSB=3)
  - instruction field widths
- Sub-module rob_tag_alloc, holding the tag pointer, occupancy counter and full logic. It takes an issue pulse, retire, flush and reset, and outputs the tag and full flag.
- Decode and hold register remain in dispatch_unit.

Test Plan:
- Reset, then 4 back-to-back INT (op 1) instructions with all stations ready -> issue_valid_out=0001 on 4 consecutive cycles, tags 0,1,2,3, pop held high, stall_out 0.
- FPMUL (op 3) at head with fpmul_rs_ready_in=0 for 3 cycles, INT behind it -> stall_out 1 for 3 cycles, INT is not issued first, pop_out 0. Then ready=1 -> issue_valid_out=0100, and INT follows the next cycle with 0001.
- 16 issues with no retire -> 17th blocks with stall_out 1. One rob_retire_in -> it issues with tag 0, showing the wrap.
- Issue and retire in the same cycle at count 15 -> issue proceeds, count stays 15.
- Opcodes 0 and 9 at the head -> neither issues, illegal_op_out rises after the 9 and stays set, no tag is consumed (next INT gets the expected tag).
- flush_in while blocked with count 5 -> next cycle hold is empty, tag 0, issue_count_out 0. rst asserted mid-cycle -> all outputs 0 with no clock edge.
